bg_removal_ctrl: RTL and testbench



---
 rtl/bg_removal_ctrl_if.sv | 30 +++
 rtl/bg_removal_ctrl.sv | 176 +++++++++++++++++
 tb/tb_bg_removal_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bg_removal_ctrl_if.sv
// rtl/bg_removal_ctrl_if.sv - controller-to-PE signal bundle for the background-removal sequencer
interface bg_removal_ctrl_if #(
  parameter int SUM_W = 12
);
  logic             start_sum;
  logic             start_bg;
  logic             sum_done;
  logic             bg_done;
  logic             ack;
  logic [SUM_W-1:0] red_sum;
  logic [SUM_W-1:0] green_sum;
  logic [SUM_W-1:0] blue_sum;
  logic [8:0]       red_exp;
  logic [8:0]       green_exp;
  logic [8:0]       blue_exp;
  logic [18:0]      threshold;
  logic [8:0]       desired_bg;

  // Sequencer side: issues start pulses and configuration, consumes done flags and sums
  modport master (
    output start_sum, start_bg, ack, red_exp, green_exp, blue_exp, threshold, desired_bg,
    input  sum_done, bg_done, red_sum, green_sum, blue_sum
  );

  // Processing-element side
  modport slave (
    input  start_sum, start_bg, ack, red_exp, green_exp, blue_exp, threshold, desired_bg,
    output sum_done, bg_done, red_sum, green_sum, blue_sum
  );
endinterface

// File: rtl/bg_removal_ctrl.sv
// rtl/bg_removal_ctrl.sv - frame sequencer: PE sum pass, mean colour, replace pass, watchdog
module bg_removal_ctrl #(
  parameter int LOG2_PIXELS = 4,
  parameter int SUM_W       = 12,
  parameter int TIMEOUT     = 1024,
  parameter int TO_W        = 11
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_start,
  input  logic [18:0]        i_cfg_threshold,
  input  logic [8:0]         i_cfg_bg,
  input  logic               i_host_ack,
  output logic               o_frame_busy,
  output logic               o_frame_done,
  output logic               o_timeout_err,
  bg_removal_ctrl_if.master  pe
);

  typedef enum logic [3:0] {
    S_IDLE, S_SUM_START, S_SUM_WAIT, S_MEAN, S_BG_START,
    S_BG_WAIT, S_PE_ACK, S_DONE, S_ERR
  } state_t;

  // Half of the pixel count, added before the shift so the mean rounds half up
  localparam logic [SUM_W:0] ROUND   = (SUM_W+1)'(1) << (LOG2_PIXELS - 1);
  localparam logic [SUM_W:0] MAX_EXP = (SUM_W+1)'(255);
  // Counter value in the last waiting cycle; leaving here puts the error flag
  // exactly TIMEOUT cycles after the start pulse
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT - 2);

  state_t           r_state;
  logic [TO_W-1:0]  r_wd;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_start_sum;
  logic             r_start_bg;
  logic             r_ack;
  logic [8:0]       r_red_exp;
  logic [8:0]       r_green_exp;
  logic [8:0]       r_blue_exp;
  logic [18:0]      r_threshold;
  logic [8:0]       r_desired_bg;
  logic [8:0]       w_red_mean;
  logic [8:0]       w_green_mean;
  logic [8:0]       w_blue_mean;
  logic             w_wd_expired;

  // Rounded per-channel mean, saturated to 8 bits; bit 8 stays clear
  function automatic logic [8:0] f_mean(input logic [SUM_W-1:0] i_sum);
    logic [SUM_W:0] v;
    v = ({1'b0, i_sum} + ROUND) >> LOG2_PIXELS;
    f_mean = (v > MAX_EXP) ? 9'd255 : {1'b0, v[7:0]};
  endfunction

  assign w_red_mean   = f_mean(pe.red_sum);
  assign w_green_mean = f_mean(pe.green_sum);
  assign w_blue_mean  = f_mean(pe.blue_sum);
  assign w_wd_expired = (r_wd == WD_LAST);

  assign o_frame_busy  = r_busy;
  assign o_frame_done  = r_done;
  assign o_timeout_err = r_err;
  assign pe.start_sum  = r_start_sum;
  assign pe.start_bg   = r_start_bg;
  assign pe.ack        = r_ack;
  assign pe.red_exp    = r_red_exp;
  assign pe.green_exp  = r_green_exp;
  assign pe.blue_exp   = r_blue_exp;
  assign pe.threshold  = r_threshold;
  assign pe.desired_bg = r_desired_bg;

  // Frame sequencer with all host and PE outputs registered on the transition edge
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_wd         <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_start_sum  <= 1'b0;
      r_start_bg   <= 1'b0;
      r_ack        <= 1'b0;
      r_red_exp    <= '0;
      r_green_exp  <= '0;
      r_blue_exp   <= '0;
      r_threshold  <= '0;
      r_desired_bg <= '0;
    end else begin
      r_start_sum <= 1'b0;
      r_start_bg  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_frame_start) begin
            r_threshold  <= i_cfg_threshold;
            r_desired_bg <= i_cfg_bg;
            r_busy       <= 1'b1;
            r_start_sum  <= 1'b1;
            r_state      <= S_SUM_START;
          end
        end
        S_SUM_START: begin
          r_wd    <= '0;
          r_state <= S_SUM_WAIT;
        end
        S_SUM_WAIT: begin
          if (pe.sum_done) begin
            r_state <= S_MEAN;
          end else if (w_wd_expired) begin
            r_err   <= 1'b1;
            r_ack   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_MEAN: begin
          r_red_exp   <= w_red_mean;
          r_green_exp <= w_green_mean;
          r_blue_exp  <= w_blue_mean;
          r_start_bg  <= 1'b1;
          r_state     <= S_BG_START;
        end
        S_BG_START: begin
          r_wd    <= '0;
          r_state <= S_BG_WAIT;
        end
        S_BG_WAIT: begin
          if (pe.bg_done) begin
            r_ack   <= 1'b1;
            r_state <= S_PE_ACK;
          end else if (w_wd_expired) begin
            r_err   <= 1'b1;
            r_ack   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_PE_ACK: begin
          // The watchdog keeps running from BG_WAIT so a PE stuck high also trips it
          if (!pe.bg_done) begin
            r_ack   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_wd_expired) begin
            r_err   <= 1'b1;
            r_state <= S_ERR;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_DONE: begin
          if (i_host_ack) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_ERR: begin
          if (i_host_ack) begin
            r_err   <= 1'b0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bg_removal_ctrl.sv
// tb/tb_bg_removal_ctrl.sv - randomized self-checking bench for bg_removal_ctrl
module tb_bg_removal_ctrl;
  localparam int LOG2_PIXELS = 4;
  localparam int SUM_W       = 12;
  localparam int TIMEOUT     = 1024;
  localparam int TO_W        = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start;
  logic [18:0] cfg_threshold;
  logic [8:0]  cfg_bg;
  logic        host_ack;
  logic        frame_busy;
  logic        frame_done;
  logic        timeout_err;

  bg_removal_ctrl_if #(.SUM_W(SUM_W)) pe_bus ();

  bg_removal_ctrl #(
    .LOG2_PIXELS (LOG2_PIXELS),
    .SUM_W       (SUM_W),
    .TIMEOUT     (TIMEOUT),
    .TO_W        (TO_W)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_frame_start   (frame_start),
    .i_cfg_threshold (cfg_threshold),
    .i_cfg_bg        (cfg_bg),
    .i_host_ack      (host_ack),
    .o_frame_busy    (frame_busy),
    .o_frame_done    (frame_done),
    .o_timeout_err   (timeout_err),
    .pe              (pe_bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // PE behaviour knobs
  logic pe_sum_en = 1'b1;
  logic pe_bg_en  = 1'b1;
  int   pe_hold   = 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected colour: rounded mean of 2^LOG2_PIXELS pixels, capped at 255
  function automatic int ref_mean(input int sum);
    int pixels;
    int m;
    pixels = 1 << LOG2_PIXELS;
    m = (sum + pixels / 2) / pixels;
    return (m > 255) ? 255 : m;
  endfunction

  // Behavioural PE: raises done the cycle after a start, holds bg_done for pe_hold ack cycles
  logic s_start_sum, s_start_bg, s_ack;
  int   hold_left;
  always begin
    @(negedge clk);
    s_start_sum = pe_bus.start_sum;
    s_start_bg  = pe_bus.start_bg;
    s_ack       = pe_bus.ack;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pe_bus.sum_done = 1'b0;
      pe_bus.bg_done  = 1'b0;
      hold_left       = 0;
    end else begin
      if (s_start_sum) pe_bus.sum_done = pe_sum_en;
      if (s_start_bg) begin
        pe_bus.sum_done = 1'b0;
        pe_bus.bg_done  = pe_bg_en;
        hold_left       = pe_hold - 1;
      end else if (s_ack && pe_bus.bg_done) begin
        if (hold_left <= 0) pe_bus.bg_done = 1'b0;
        else hold_left--;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {frame_busy, frame_done, timeout_err,
                        pe_bus.start_sum, pe_bus.start_bg, pe_bus.ack}, 32'd0);
    chk({tag, "_exp"}, {pe_bus.red_exp, pe_bus.green_exp, pe_bus.blue_exp}, 32'd0);
    chk({tag, "_cfg"}, {pe_bus.threshold, pe_bus.desired_bg}, 32'd0);
  endtask

  task automatic set_frame(input int r, input int g, input int b,
                           input logic [18:0] thr, input logic [8:0] bg);
    pe_bus.red_sum   = r[SUM_W-1:0];
    pe_bus.green_sum = g[SUM_W-1:0];
    pe_bus.blue_sum  = b[SUM_W-1:0];
    cfg_threshold    = thr;
    cfg_bg           = bg;
  endtask

  // Runs one frame from the accept edge to frame_done and checks everything seen on the way
  task automatic run_frame(input int r, input int g, input int b,
                           input logic [18:0] thr, input logic [8:0] bg,
                           input int hold, input bit keep_start, input string tag);
    int   cyc;
    int   n_start;
    int   n_ackhi;
    logic [18:0] seen_thr;
    logic [8:0]  seen_bg;
    bit   done;
    @(negedge clk);
    set_frame(r, g, b, thr, bg);
    pe_hold     = hold;
    frame_start = 1'b1;
    @(posedge clk);
    cyc = 0; n_start = 0; n_ackhi = 0; done = 0;
    seen_thr = '0; seen_bg = '0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!keep_start) frame_start = 1'b0;
      if (pe_bus.start_sum) n_start++;
      if (pe_bus.start_bg) begin
        seen_thr = pe_bus.threshold;
        seen_bg  = pe_bus.desired_bg;
      end
      if (pe_bus.ack && pe_bus.bg_done) n_ackhi++;
      if (frame_done) done = 1;
    end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_latency"}, cyc, 7 + hold);
    chk({tag, "_start_pulses"}, n_start, 1);
    chk({tag, "_thr_at_start_bg"}, seen_thr, thr);
    chk({tag, "_bg_at_start_bg"}, seen_bg, bg);
    chk({tag, "_ack_hold"}, n_ackhi, hold);
    chk({tag, "_exp_r"}, pe_bus.red_exp, ref_mean(r));
    chk({tag, "_exp_g"}, pe_bus.green_exp, ref_mean(g));
    chk({tag, "_exp_b"}, pe_bus.blue_exp, ref_mean(b));
    chk({tag, "_busy_err_ack"}, {frame_busy, timeout_err, pe_bus.ack}, 3'b100);
  endtask

  // Acknowledge a finished or failed frame; caller is sitting on a negedge
  task automatic ack_to_idle(input string tag);
    host_ack    = 1'b1;
    frame_start = 1'b0;
    @(negedge clk);
    host_ack = 1'b0;
    chk({tag, "_idle"}, {frame_busy, frame_done, timeout_err, pe_bus.ack}, 4'b0000);
  endtask

  task automatic run_timeout(input bit at_sum, input string tag);
    int  k;
    bit  seen;
    pe_sum_en = !at_sum;
    pe_bg_en  = at_sum;
    @(negedge clk);
    set_frame($urandom_range(0, 4095), 100, 200, 19'd1234, 9'd7);
    frame_start = 1'b1;
    @(posedge clk);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (at_sum ? pe_bus.start_sum : pe_bus.start_bg) seen = 1;
    end
    chk({tag, "_start_seen"}, seen, 1);
    k = 0;
    while (!timeout_err && k < TIMEOUT + 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_cycles"}, k, TIMEOUT);
    chk({tag, "_err_state"}, {timeout_err, pe_bus.ack, frame_busy, frame_done}, 4'b1110);
    repeat (2) @(negedge clk);
    chk({tag, "_err_held"}, {timeout_err, pe_bus.ack}, 2'b11);
    ack_to_idle(tag);
    pe_sum_en = 1'b1;
    pe_bg_en  = 1'b1;
  endtask

  initial begin
    int  r, g, b, cyc;
    bit  seen;
    frame_start   = 1'b0;
    host_ack      = 1'b0;
    cfg_threshold = '0;
    cfg_bg        = '0;
    set_frame(0, 0, 0, '0, '0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Directed frame with a half-way rounding case on green
    run_frame(32'h800, 32'h0F8, 32'h000, 19'd500, 9'h010, 1, 1'b0, "normal");
    ack_to_idle("normal");

    // Saturation: 4095 rounds to 256 and must clip to 255
    run_frame(32'hFFF, 32'hFFF, 32'hFFF, 19'h7FFFF, 9'h1FF, 1, 1'b0, "sat");
    ack_to_idle("sat");

    // Rounding boundaries just under and at half a pixel
    run_frame(7, 8, 32'hFF7, 19'd1, 9'd1, 1, 1'b0, "round");
    ack_to_idle("round");

    // PE holds bg_done through five ack cycles
    run_frame(32'h123, 32'h456, 32'h789, 19'd9999, 9'd55, 5, 1'b0, "hold5");
    ack_to_idle("hold5");

    // frame_start held high the whole frame, then host_ack and frame_start together
    run_frame(32'h200, 32'h300, 32'h400, 19'd42, 9'd3, 1, 1'b1, "held_start");
    host_ack    = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    host_ack = 1'b0;
    chk("proto_idle_first", {frame_busy, frame_done, pe_bus.start_sum}, 3'b000);
    @(negedge clk);
    frame_start = 1'b0;
    chk("proto_next_accept", {frame_busy, pe_bus.start_sum}, 2'b11);
    cyc = 1;
    while (!frame_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("proto_next_latency", cyc, 8);
    chk("proto_next_exp_r", pe_bus.red_exp, ref_mean(32'h200));
    ack_to_idle("proto_next");

    // Randomized frames against the reference mean
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(4000, 4095);
        g = $urandom_range(4000, 4095);
      end else begin
        r = $urandom_range(0, 4095);
        g = $urandom_range(0, 4095);
      end
      b = $urandom_range(0, 4095);
      run_frame(r, g, b, 19'($urandom), 9'($urandom), $urandom_range(1, 4), 1'b0,
                $sformatf("rand%0d", n));
      ack_to_idle($sformatf("rand%0d", n));
    end

    // Watchdog on both PE passes
    run_timeout(1'b1, "to_sum");
    run_timeout(1'b0, "to_bg");

    // Asynchronous reset while waiting on the replace pass
    pe_bg_en = 1'b0;
    @(negedge clk);
    set_frame(32'h555, 32'h666, 32'h777, 19'd321, 9'd9);
    frame_start = 1'b1;
    @(posedge clk);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (pe_bus.start_bg) seen = 1;
    end
    chk("midrst_start_bg_seen", seen, 1);
    repeat (3) @(negedge clk);
    chk("midrst_pre_busy_exp", {frame_busy, pe_bus.red_exp}, {1'b1, 9'(ref_mean(32'h555))});
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    pe_bg_en = 1'b1;
    r = $urandom_range(0, 4095);
    run_frame(r, 32'h0F7, 32'h0F8, 19'd77, 9'd11, 1, 1'b0, "post_rst");
    ack_to_idle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
